// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a sync FIFO in framed bursts onto a valid/ready stream
// Optional statistics outputs (burst_cnt, partial_cnt) are enabled by defining FIFO_BURST_STATS_EN.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10,
  parameter int BURST_LEN  = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_BITS-1:0]  fifo_usedw,
  output logic                  fifo_rdreq,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
`ifdef FIFO_BURST_STATS_EN
  output logic [15:0]           burst_cnt,
  output logic [15:0]           partial_cnt,
`endif
  output logic                  busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_BITS-1:0] BURST_LEN_C  = ADDR_BITS'(BURST_LEN);
  localparam logic [ADDR_BITS-1:0] ONE_C        = ADDR_BITS'(1);
  localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ADDR_BITS-1:0]   burst_len_q, burst_len_d;
  logic [ADDR_BITS-1:0]   issued_q, issued_d;
  logic [ADDR_BITS-1:0]   sent_q, sent_d;
  logic                   inflight_q;
  logic [DATA_WIDTH-1:0]  buf_mem_q [2];
  logic                   buf_head_q;
  logic [1:0]             buf_cnt_q, buf_cnt_d;

  logic       pop, push, buf_pop, buf_tail;
  logic [1:0] pending;

  // An empty buffer lets the word arriving from the FIFO bypass straight to the output.
  always_comb begin
    out_valid = (buf_cnt_q != 2'd0) || inflight_q;
    out_data  = '0;
    if (buf_cnt_q != 2'd0) begin
      out_data = buf_mem_q[buf_head_q];
    end else if (inflight_q) begin
      out_data = fifo_data;
    end
    out_sop   = out_valid && (sent_q == '0);
    out_eop   = out_valid && (sent_q == burst_len_q - ONE_C);
    pop       = out_valid && out_ready;
    push      = inflight_q && !((buf_cnt_q == 2'd0) && pop);
    buf_pop   = pop && (buf_cnt_q != 2'd0);
    buf_tail  = buf_head_q ^ buf_cnt_q[0];
    buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, buf_pop};
    pending   = buf_cnt_q + {1'b0, inflight_q};
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    fifo_rdreq = (state_q == S_BURST) && !fifo_empty &&
                 (issued_q < burst_len_q) && (pending < 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    burst_len_d = burst_len_q;
    issued_d    = issued_q;
    sent_d      = sent_q + ADDR_BITS'(pop);
    case (state_q)
      S_IDLE: begin
        burst_len_d = '0;
        issued_d    = '0;
        sent_d      = '0;
        if (fifo_usedw >= BURST_LEN_C) begin
          state_d     = S_BURST;
          burst_len_d = BURST_LEN_C;
          timer_d     = '0;
        end else if (fifo_empty) begin
          timer_d = '0;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TIMEOUT_LAST) begin
            state_d     = S_BURST;
            burst_len_d = fifo_usedw;
            timer_d     = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_BURST: begin
        issued_d = issued_q + ADDR_BITS'(fifo_rdreq);
        if (issued_d == burst_len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((sent_q == burst_len_q) && (buf_cnt_q == 2'd0) && !inflight_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      burst_len_q  <= '0;
      issued_q     <= '0;
      sent_q       <= '0;
      inflight_q   <= 1'b0;
      buf_mem_q[0] <= '0;
      buf_mem_q[1] <= '0;
      buf_head_q   <= 1'b0;
      buf_cnt_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      burst_len_q <= burst_len_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      inflight_q  <= fifo_rdreq;
      buf_cnt_q   <= buf_cnt_d;
      if (push) begin
        buf_mem_q[buf_tail] <= fifo_data;
      end
      if (buf_pop) begin
        buf_head_q <= ~buf_head_q;
      end
    end
  end

`ifdef FIFO_BURST_STATS_EN
  logic        partial_q;
  logic [15:0] burst_cnt_q, partial_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      partial_q     <= 1'b0;
      burst_cnt_q   <= '0;
      partial_cnt_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && (state_d == S_BURST)) begin
        partial_q <= (fifo_usedw < BURST_LEN_C);
      end
      if (pop && out_eop) begin
        if (burst_cnt_q != 16'hFFFF) begin
          burst_cnt_q <= burst_cnt_q + 16'd1;
        end
        if (partial_q && (partial_cnt_q != 16'hFFFF)) begin
          partial_cnt_q <= partial_cnt_q + 16'd1;
        end
      end
    end
  end

  assign burst_cnt   = burst_cnt_q;
  assign partial_cnt = partial_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
`timescale 1ns/1ps
module tb_fifo_burst_reader;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int AB = 10;

  function automatic int bl_of(input int g);
    case (g)
      2: return 8;
      3: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int to_of(input int g);
    case (g)
      1: return 8;
      4: return 0;
      default: return 255;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n      [N];
  logic [DW-1:0] fifo_data  [N];
  logic          fifo_empty [N];
  logic [AB-1:0] fifo_usedw [N];
  logic          fifo_rdreq [N];
  logic [DW-1:0] out_data   [N];
  logic          out_valid  [N];
  logic          out_ready  [N];
  logic          out_sop    [N];
  logic          out_eop    [N];
  logic          busy       [N];
`ifdef FIFO_BURST_STATS_EN
  logic [15:0]   burst_cnt   [N];
  logic [15:0]   partial_cnt [N];
`endif

  logic [DW-1:0] fmem [N][256];
  int            wp   [N];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    int            rp;
    logic [DW-1:0] fdata;
    initial begin
      rp    = 0;
      fdata = '0;
    end
    always @(posedge clk) begin
      if (fifo_rdreq[g] && (wp[g] != rp)) begin
        fdata <= fmem[g][rp[7:0]];
        rp    <= rp + 1;
      end
    end
    assign fifo_empty[g] = (wp[g] == rp);
    assign fifo_usedw[g] = AB'(wp[g] - rp);
    assign fifo_data[g]  = fdata;

    fifo_burst_reader #(
      .DATA_WIDTH(DW), .ADDR_BITS(AB), .BURST_LEN(bl_of(g)), .TIMEOUT(to_of(g))
    ) u_dut (
      .clk(clk), .rst(rst_n[g]),
      .fifo_data(fifo_data[g]), .fifo_empty(fifo_empty[g]), .fifo_usedw(fifo_usedw[g]),
      .fifo_rdreq(fifo_rdreq[g]),
      .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_sop(out_sop[g]), .out_eop(out_eop[g]),
`ifdef FIFO_BURST_STATS_EN
      .burst_cnt(burst_cnt[g]), .partial_cnt(partial_cnt[g]),
`endif
      .busy(busy[g])
    );
  end

  task automatic push(input int k, input logic [DW-1:0] w);
    fmem[k][wp[k][7:0]] = w;
    wp[k] = wp[k] + 1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; out_ready[k] = 1'b0; wp[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_checks++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", k, out_valid[k]); end
      n_checks++; if (fifo_rdreq[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq[%0d]: got %b want 0", k, fifo_rdreq[k]); end
      n_checks++; if (out_sop[k] !== 1'b0) begin n_fail++; $display("FAIL reset_sop[%0d]: got %b want 0", k, out_sop[k]); end
      n_checks++; if (out_eop[k] !== 1'b0) begin n_fail++; $display("FAIL reset_eop[%0d]: got %b want 0", k, out_eop[k]); end
      n_checks++; if (out_data[k] !== 16'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0000", k, out_data[k]); end
      n_checks++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_full_burst();
    int first_rd, last_rd, n_rd, busy_lo;
    logic [DW-1:0] got[$];
    int xc[$];
    logic sops[$], eops[$];
    first_rd = -1; last_rd = -1; n_rd = 0; busy_lo = -1;
    for (int w = 1; w <= 4; w++) push(0, DW'(w));
    for (int i = 0; i < 40; i++) begin
      out_ready[0] = 1'b1;
      @(negedge clk);
      if (fifo_rdreq[0]) begin if (first_rd < 0) first_rd = i; last_rd = i; n_rd++; end
      if (out_valid[0] && out_ready[0]) begin
        got.push_back(out_data[0]); xc.push_back(i); sops.push_back(out_sop[0]); eops.push_back(out_eop[0]);
      end
      if (xc.size() == 4 && busy_lo < 0 && !busy[0]) busy_lo = i;
      @(posedge clk); #1;
    end
    n_checks++; if (n_rd !== 4) begin n_fail++; $display("FAIL full_rdreq_count: got %0d want 4", n_rd); end
    n_checks++; if (last_rd - first_rd !== 3) begin n_fail++; $display("FAIL full_rdreq_consecutive: span %0d want 3", last_rd - first_rd); end
    n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL full_xfer_count: got %0d want 4", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      n_checks++; if (got[j] !== DW'(j + 1)) begin n_fail++; $display("FAIL full_data[%0d]: got %h want %h", j, got[j], DW'(j + 1)); end
      n_checks++; if (xc[j] !== first_rd + 1 + j) begin n_fail++; $display("FAIL full_timing[%0d]: cycle %0d want %0d", j, xc[j], first_rd + 1 + j); end
      n_checks++; if (sops[j] !== (j == 0)) begin n_fail++; $display("FAIL full_sop[%0d]: got %b want %b", j, sops[j], (j == 0)); end
      n_checks++; if (eops[j] !== (j == 3)) begin n_fail++; $display("FAIL full_eop[%0d]: got %b want %b", j, eops[j], (j == 3)); end
    end
    if (xc.size() == 4) begin
      n_checks++; if (busy_lo !== xc[3] + 2) begin n_fail++; $display("FAIL full_busy_fall: cycle %0d want %0d", busy_lo, xc[3] + 2); end
    end
  endtask

  task automatic test_timeout();
    int first_rd;
    logic [DW-1:0] got[$];
    logic sops[$], eops[$];
    first_rd = -1;
    push(1, 16'h00A0); push(1, 16'h00A1);
    for (int i = 0; i < 40; i++) begin
      out_ready[1] = 1'b1;
      @(negedge clk);
      if (fifo_rdreq[1] && first_rd < 0) first_rd = i;
      if (out_valid[1] && out_ready[1]) begin
        got.push_back(out_data[1]); sops.push_back(out_sop[1]); eops.push_back(out_eop[1]);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (first_rd !== 8) begin n_fail++; $display("FAIL timeout_start: cycle %0d want 8", first_rd); end
    n_checks++; if (got.size() !== 2) begin n_fail++; $display("FAIL timeout_xfer_count: got %0d want 2", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      n_checks++; if (got[j] !== DW'(16'h00A0 + j)) begin n_fail++; $display("FAIL timeout_data[%0d]: got %h want %h", j, got[j], DW'(16'h00A0 + j)); end
      n_checks++; if (sops[j] !== (j == 0)) begin n_fail++; $display("FAIL timeout_sop[%0d]: got %b", j, sops[j]); end
      n_checks++; if (eops[j] !== (j == 1)) begin n_fail++; $display("FAIL timeout_eop[%0d]: got %b", j, eops[j]); end
    end
`ifdef FIFO_BURST_STATS_EN
    n_checks++; if (partial_cnt[1] !== 16'd1) begin n_fail++; $display("FAIL timeout_partial_cnt: got %0d want 1", partial_cnt[1]); end
    n_checks++; if (burst_cnt[1] !== 16'd1) begin n_fail++; $display("FAIL timeout_burst_cnt: got %0d want 1", burst_cnt[1]); end
`endif
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp[$], got[$], pdata;
    logic sops[$], eops[$], pstall, psop, peop;
    int n_rd, max_out, stab_err, outst;
    n_rd = 0; max_out = 0; stab_err = 0; pstall = 1'b0; pdata = '0; psop = 1'b0; peop = 1'b0;
    for (int j = 0; j < 8; j++) begin
      exp.push_back(DW'($urandom)); push(2, exp[j]);
    end
    for (int i = 0; i < 80; i++) begin
      out_ready[2] = ((i % 4) == 0) || ((i % 4) == 3);
      @(negedge clk);
      if (pstall && (!out_valid[2] || out_data[2] !== pdata || out_sop[2] !== psop || out_eop[2] !== peop)) stab_err++;
      outst = n_rd + (fifo_rdreq[2] ? 1 : 0) - got.size();
      if (outst > max_out) max_out = outst;
      if (fifo_rdreq[2]) n_rd++;
      pstall = out_valid[2] && !out_ready[2];
      pdata = out_data[2]; psop = out_sop[2]; peop = out_eop[2];
      if (out_valid[2] && out_ready[2]) begin
        got.push_back(out_data[2]); sops.push_back(out_sop[2]); eops.push_back(out_eop[2]);
      end
      @(posedge clk); #1;
    end
    out_ready[2] = 1'b0;
    n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL bp_xfer_count: got %0d want 8", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      n_checks++; if (got[j] !== exp[j]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", j, got[j], exp[j]); end
      n_checks++; if (sops[j] !== (j == 0) || eops[j] !== (j == 7)) begin n_fail++; $display("FAIL bp_frame[%0d]: sop %b eop %b", j, sops[j], eops[j]); end
    end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stall_stable: %0d changes while stalled, want 0", stab_err); end
    n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: max %0d want <= 2", max_out); end
  endtask

  task automatic test_single();
    int n_rd;
    logic [DW-1:0] got[$];
    logic sops[$], eops[$];
    n_rd = 0;
    push(3, 16'h0055);
    for (int i = 0; i < 20; i++) begin
      out_ready[3] = 1'b1;
      @(negedge clk);
      if (fifo_rdreq[3]) n_rd++;
      if (out_valid[3] && out_ready[3]) begin
        got.push_back(out_data[3]); sops.push_back(out_sop[3]); eops.push_back(out_eop[3]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL single_rdreq: got %0d want 1", n_rd); end
    n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      n_checks++; if (got[0] !== 16'h0055) begin n_fail++; $display("FAIL single_data: got %h want 0055", got[0]); end
      n_checks++; if (sops[0] !== 1'b1 || eops[0] !== 1'b1) begin n_fail++; $display("FAIL single_frame: sop %b eop %b want 1 1", sops[0], eops[0]); end
    end
    n_checks++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b want 0", busy[3]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp[$], got[$];
    logic sops[$], eops[$];
    int n_rd, n_x, hit, first_rd, busy0;
    n_rd = 0; n_x = 0; hit = 0; first_rd = -1; busy0 = 1;
    for (int j = 0; j < 8; j++) begin
      exp.push_back(DW'($urandom)); push(2, exp[j]);
    end
    for (int i = 0; i < 40 && hit == 0; i++) begin
      out_ready[2] = 1'b1;
      @(negedge clk);
      if (out_valid[2] && n_x == 2) begin
        hit = 1;
      end else begin
        if (fifo_rdreq[2]) n_rd++;
        if (out_valid[2] && out_ready[2]) n_x++;
        @(posedge clk); #1;
      end
    end
    n_checks++; if (hit !== 1) begin n_fail++; $display("FAIL rstmid_reach_third: reached %0d want 1", hit); end
    #1; rst_n[2] = 1'b0; #1;
    n_checks++; if (out_valid[2] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid[2]); end
    n_checks++; if (fifo_rdreq[2] !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdreq: got %b want 0", fifo_rdreq[2]); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n[2] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready[2] = 1'b1;
      @(negedge clk);
      if (i == 0) busy0 = busy[2];
      if (fifo_rdreq[2] && first_rd < 0) first_rd = i;
      if (out_valid[2] && out_ready[2]) begin
        got.push_back(out_data[2]); sops.push_back(out_sop[2]); eops.push_back(out_eop[2]);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (busy0 !== 0) begin n_fail++; $display("FAIL rstmid_idle: busy %0d want 0", busy0); end
    n_checks++; if (first_rd !== 255) begin n_fail++; $display("FAIL rstmid_timer_cleared: first read %0d want 255", first_rd); end
    n_checks++; if (got.size() !== 8 - n_rd) begin n_fail++; $display("FAIL rstmid_remaining: got %0d want %0d", got.size(), 8 - n_rd); end
    for (int j = 0; j < got.size() && n_rd + j < 8; j++) begin
      n_checks++; if (got[j] !== exp[n_rd + j]) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h want %h", j, got[j], exp[n_rd + j]); end
      n_checks++; if (sops[j] !== (j == 0) || eops[j] !== (j == 7 - n_rd)) begin n_fail++; $display("FAIL rstmid_frame[%0d]: sop %b eop %b", j, sops[j], eops[j]); end
    end
  endtask

  task automatic test_no_timeout();
    int n_rd, busy_seen, first_rd;
    logic [DW-1:0] got[$];
    logic sops[$], eops[$];
    n_rd = 0; busy_seen = 0; first_rd = -1;
    for (int j = 0; j < 3; j++) push(4, DW'(16'h0C00 + j));
    for (int i = 0; i < 300; i++) begin
      out_ready[4] = 1'b1;
      @(negedge clk);
      if (fifo_rdreq[4]) n_rd++;
      if (busy[4]) busy_seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL notimeout_rdreq: got %0d want 0", n_rd); end
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL notimeout_busy: %0d busy cycles want 0", busy_seen); end
    push(4, 16'h0C03);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_rdreq[4] && first_rd < 0) first_rd = i;
      if (out_valid[4] && out_ready[4]) begin
        got.push_back(out_data[4]); sops.push_back(out_sop[4]); eops.push_back(out_eop[4]);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (first_rd !== 1) begin n_fail++; $display("FAIL notimeout_start: cycle %0d want 1", first_rd); end
    n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL notimeout_count: got %0d want 4", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      n_checks++; if (got[j] !== DW'(16'h0C00 + j)) begin n_fail++; $display("FAIL notimeout_data[%0d]: got %h want %h", j, got[j], DW'(16'h0C00 + j)); end
      n_checks++; if (sops[j] !== (j == 0) || eops[j] !== (j == 3)) begin n_fail++; $display("FAIL notimeout_frame[%0d]: sop %b eop %b", j, sops[j], eops[j]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp[$], got[$], pdata;
    logic pstall, psop, peop;
    int eop_cyc[$], brst_rd[$];
    int n_rd, stab_err, frame_err, gap_err;
    n_rd = 0; stab_err = 0; frame_err = 0; gap_err = 0; pstall = 1'b0; pdata = '0; psop = 1'b0; peop = 1'b0;
    for (int j = 0; j < 12; j++) begin
      exp.push_back(DW'($urandom)); push(0, exp[j]);
    end
    for (int i = 0; i < 200; i++) begin
      out_ready[0] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pstall && (!out_valid[0] || out_data[0] !== pdata || out_sop[0] !== psop || out_eop[0] !== peop)) stab_err++;
      pstall = out_valid[0] && !out_ready[0];
      pdata = out_data[0]; psop = out_sop[0]; peop = out_eop[0];
      if (fifo_rdreq[0]) begin
        if ((n_rd % 4) == 0) brst_rd.push_back(i);
        n_rd++;
      end
      if (out_valid[0] && out_ready[0]) begin
        if (out_sop[0] !== ((got.size() % 4) == 0) || out_eop[0] !== ((got.size() % 4) == 3)) frame_err++;
        if ((got.size() % 4) == 3) eop_cyc.push_back(i);
        got.push_back(out_data[0]);
      end
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (brst_rd.size() > b + 1 && eop_cyc.size() > b && brst_rd[b + 1] < eop_cyc[b] + 2) gap_err++;
    end
    n_checks++; if (got.size() !== 12) begin n_fail++; $display("FAIL b2b_count: got %0d want 12", got.size()); end
    for (int j = 0; j < got.size() && j < 12; j++) begin
      n_checks++; if (got[j] !== exp[j]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", j, got[j], exp[j]); end
    end
    n_checks++; if (frame_err !== 0) begin n_fail++; $display("FAIL b2b_frame: %0d errors want 0", frame_err); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL b2b_stall_stable: %0d changes want 0", stab_err); end
    n_checks++; if (gap_err !== 0) begin n_fail++; $display("FAIL b2b_idle_gap: %0d overlaps want 0", gap_err); end
    n_checks++; if (brst_rd.size() !== 3) begin n_fail++; $display("FAIL b2b_bursts: got %0d want 3", brst_rd.size()); end
`ifdef FIFO_BURST_STATS_EN
    n_checks++; if (burst_cnt[0] !== 16'd4) begin n_fail++; $display("FAIL b2b_burst_cnt: got %0d want 4", burst_cnt[0]); end
    n_checks++; if (partial_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL b2b_partial_cnt: got %0d want 0", partial_cnt[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_no_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
